// File: rtl/frame_writer.sv
// frame_writer: buffers incoming {address,color} pixels in a small FIFO and
// drains them one at a time to a frame memory with a req/ack handshake.
//
// Ports:
//   clk, rst          - single clock, asynchronous active-high reset
//   pix_valid         - address/color valid this cycle
//   address, color    - linear pixel index (x + 640*y) and 3-bit color
//   VGA_ready         - upstream may present pixels (registered-count decode)
//   mem_req           - write request, held with mem_addr/mem_data until ack
//   mem_addr,mem_data - write address/color
//   mem_ack           - memory accepted the current write
//   frame_done        - one-cycle pulse after the last pixel (307199) is written
//   overflow          - sticky: a valid pixel was dropped on a full FIFO
//   bad_addr          - sticky: a valid pixel with address >= 307200 was dropped
//   frame_count       - (only with FRAME_WRITER_FRAME_CNT_EN) frames completed,
//                       16-bit wrapping
//
// Optional feature macro: FRAME_WRITER_FRAME_CNT_EN
module frame_writer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [18:0] address,
    input  logic [2:0]  color,
    output logic        VGA_ready,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    output logic [2:0]  mem_data,
    input  logic        mem_ack,
    output logic        frame_done,
    output logic        overflow,
    output logic        bad_addr
`ifdef FRAME_WRITER_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [18:0]   NUM_PIX   = 19'd307200;
    localparam logic [18:0]   LAST_ADDR = 19'd307199;

    typedef enum logic {IDLE, REQ} state_t;

    state_t         state, state_next;
    logic [21:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic           addr_ok, full, push, pop;
    logic           load, load_second;
    logic [PW-1:0]  head_idx;
    logic           done_next;

    assign addr_ok   = (address < NUM_PIX);
    assign full      = (count == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = pix_valid && addr_ok && (!full || pop);
    assign VGA_ready = (count <= READY_MAX);

    // The head entry stays in the FIFO until acknowledged; on ack with more
    // data queued, the entry behind the head is loaded for back-to-back writes.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        load_second = 1'b0;
        pop         = 1'b0;
        mem_req     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = REQ;
                    load       = 1'b1;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pop = 1'b1;
                    if (count > CW'(1)) begin
                        load        = 1'b1;
                        load_second = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign head_idx  = load_second ? (rptr + PW'(1)) : rptr;
    assign done_next = pop && (mem_addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= {address, color};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            bad_addr   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load) {mem_addr, mem_data} <= fifo_mem[head_idx];
            frame_done <= done_next;
            if (pix_valid && !addr_ok)                bad_addr <= 1'b1;
            if (pix_valid && addr_ok && full && !pop) overflow <= 1'b1;
        end
    end

`ifdef FRAME_WRITER_FRAME_CNT_EN
    // Counts on the same edge that raises frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            frame_count <= '0;
        else if (done_next) frame_count <= frame_count + 16'd1;
    end
`endif

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of two, min 4): pixel FIFO entries.
REQ-002 SHALL have parameter AFULL_MARGIN, default 2: free entries below which VGA_ready deasserts.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pix_valid  input  1  address/color valid this cycle.
REQ-006 SHALL have port address  input  19  linear pixel index (x + 640*y).
REQ-007 SHALL have port color  input  3  pixel color.
REQ-008 SHALL have port VGA_ready  output  1  upstream may present pixels.
REQ-009 SHALL have port mem_req  output  1  write request to frame memory.
REQ-010 SHALL have port mem_addr  output  19  write address, stable while mem_req high.
REQ-011 SHALL have port mem_data  output  3  write color, stable while mem_req high.
REQ-012 SHALL have port mem_ack  input  1  memory accepted current write.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse, last pixel (address 307199) written.
REQ-014 SHALL have port overflow  output  1  sticky: a valid pixel was dropped on full FIFO.
REQ-015 SHALL have port bad_addr  output  1  sticky: a valid pixel with address >= 307200 was discarded.

Function
REQ-016 SHALL push {address,color} into the FIFO on any cycle with pix_valid=1, FIFO not full, address < 307200.
REQ-017 SHALL discard pix_valid pixels with address >= 307200 and set bad_addr; FIFO unchanged.
REQ-018 SHALL discard pix_valid pixels arriving while full with no pop that cycle and set overflow.
REQ-019 SHALL accept a push on a full FIFO when a pop occurs the same cycle; count unchanged.
REQ-020 SHALL drive VGA_ready = 1 iff count <= FIFO_DEPTH - AFULL_MARGIN, decoded from registered count (no input-to-output path).
REQ-021 SHALL use write FSM with states IDLE and REQ.
REQ-022 IDLE -> REQ when FIFO non-empty: on that edge load head into mem_addr/mem_data and set mem_req=1.
REQ-023 In REQ, SHALL hold mem_req, mem_addr, mem_data constant until mem_ack sampled 1.
REQ-024 On mem_ack=1 in REQ SHALL pop head; if FIFO holds another entry SHALL load it and remain in REQ (back-to-back, no idle cycle), else go IDLE with mem_req=0.
REQ-025 SHALL ignore mem_ack while in IDLE.
REQ-026 Latency: pixel pushed into empty FIFO with FSM IDLE SHALL appear on mem_req/mem_addr two edges after the push edge.
REQ-027 SHALL pulse frame_done for exactly one cycle, the cycle after mem_ack accepts address 307199.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-029 SHALL preserve write order (FIFO order) exactly.

Reset
REQ-030 rst=1 SHALL asynchronously force: FIFO empty, FSM IDLE, mem_req=0, mem_addr=0, mem_data=0, frame_done=0, overflow=0, bad_addr=0; VGA_ready therefore 1.
REQ-031 rst asserted while mem_req=1 SHALL drop mem_req immediately and abandon the pending write; no frame_done.
REQ-032 Sticky flags SHALL clear only on rst.

Configuration
REQ-033 Macro FRAME_WRITER_FRAME_CNT_EN: when defined, SHALL add output frame_count (16 bits), reset 0, incremented on each frame_done pulse, wrapping 65535 -> 0.
REQ-034 Without FRAME_WRITER_FRAME_CNT_EN, frame_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 After reset, push address 5 color 3'b101, mem_ack held 1 -> mem_req high 2 edges later, mem_addr=5, mem_data=5, single write, FIFO empty.
REQ-036 mem_ack held 0, push 9 pixels (depth 8) -> VGA_ready falls once count reaches 7, 9th pixel dropped, overflow=1, first 8 written in order once ack released.
REQ-037 Push address 307200 -> no mem_req, bad_addr=1, count stays 0.
REQ-038 Push 307199, ack on 3rd REQ cycle -> mem_req held 3 cycles stable, frame_done one-cycle pulse next cycle; frame_count=1 with macro.
REQ-039 Full FIFO, push and ack same cycle -> push accepted, overflow stays 0, count stays 8.
REQ-040 Assert rst mid-REQ with 4 entries queued -> mem_req 0 immediately (before clock edge), FIFO empty, VGA_ready 1, no writes after release.
